// File: rtl/fir_host_driver_if.sv
// Host-driver bundle: config port, sample/result handshakes and the
// strobe/busy link to the FIR filter core.
interface fir_host_driver_if #(
    parameter int DW = 16,
    parameter int AW = 2
);
    logic          cfg_we;
    logic [AW-1:0] cfg_addr;
    logic [DW-1:0] cfg_data;
    logic          start_load;
    logic          load_done;

    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;

    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_err;

    logic [DW-1:0] sample_data;
    logic [DW-1:0] fir_coefficient;
    logic          load_coeff;
    logic          data_ready;
    logic          modwait;
    logic [DW-1:0] fir_out;
    logic          err;
    logic          timeout;

    modport master (
        input  cfg_we,
        input  cfg_addr,
        input  cfg_data,
        input  start_load,
        input  in_valid,
        input  in_data,
        input  out_ready,
        input  modwait,
        input  fir_out,
        input  err,
        output load_done,
        output in_ready,
        output out_valid,
        output out_data,
        output out_err,
        output sample_data,
        output fir_coefficient,
        output load_coeff,
        output data_ready,
        output timeout
    );

    modport slave (
        output cfg_we,
        output cfg_addr,
        output cfg_data,
        output start_load,
        output in_valid,
        output in_data,
        output out_ready,
        output modwait,
        output fir_out,
        output err,
        input  load_done,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_err,
        input  sample_data,
        input  fir_coefficient,
        input  load_coeff,
        input  data_ready,
        input  timeout
    );
endinterface

// File: rtl/fir_host_driver.sv
// Initiator for the FIR filter: loads coefficients, then pushes samples
// through the filter one at a time and returns each result.
module fir_host_driver #(
    parameter int NCOEFF  = 4,
    parameter int DW      = 16,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    fir_host_driver_if.master  bus
);
    localparam int IW = (NCOEFF > 1) ? $clog2(NCOEFF) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        C_REQ,
        S_REQ,
        WAIT_LOW,
        FAULT
    } state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          pending_q, pending_d;
    logic          ctxn_q, ctxn_d;
    logic          load_done_q, load_done_d;
    logic          timeout_q, timeout_d;
    logic          load_coeff_q, load_coeff_d;
    logic          data_ready_q, data_ready_d;
    logic          out_valid_q, out_valid_d;
    logic          out_err_q, out_err_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic [DW-1:0] sample_q, sample_d;
    logic [DW-1:0] fcoef_q, fcoef_d;
    logic [DW-1:0] coeff_q [NCOEFF];
    logic [DW-1:0] coeff_d [NCOEFF];

    logic pend;
    logic in_ready_w;
    logic in_xfer;
    logic tmo_hit;

    assign pend       = pending_q | bus.start_load;
    assign in_ready_w = (state_q == IDLE) & ~bus.modwait & ~pend &
                        load_done_q & ~out_valid_q;
    assign in_xfer    = bus.in_valid & in_ready_w;
    assign tmo_hit    = (tcnt_q == TW'(TIMEOUT - 1));

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        pending_d   = pend;
        ctxn_d      = ctxn_q;
        load_done_d = load_done_q;
        timeout_d   = timeout_q;
        out_valid_d = out_valid_q;
        out_err_d   = out_err_q;
        out_data_d  = out_data_q;
        sample_d    = sample_q;
        fcoef_d     = fcoef_q;
        coeff_d     = coeff_q;

        if (bus.cfg_we) begin
            coeff_d[bus.cfg_addr] = bus.cfg_data;
        end
        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE, FAULT: begin
                if (!bus.modwait && pend) begin
                    // Latched from the register file: later cfg writes
                    // only reach transactions latched after them.
                    pending_d   = 1'b0;
                    load_done_d = 1'b0;
                    timeout_d   = 1'b0;
                    idx_d       = '0;
                    ctxn_d      = 1'b1;
                    fcoef_d     = coeff_q[0];
                    state_d     = C_REQ;
                end else if (state_q == IDLE && in_xfer) begin
                    ctxn_d   = 1'b0;
                    sample_d = bus.in_data;
                    state_d  = S_REQ;
                end
            end
            C_REQ, S_REQ: begin
                if (bus.modwait) begin
                    state_d = WAIT_LOW;
                end else if (tmo_hit) begin
                    state_d = FAULT;
                end
            end
            WAIT_LOW: begin
                if (!bus.modwait) begin
                    if (!ctxn_q) begin
                        out_data_d  = bus.fir_out;
                        out_err_d   = bus.err;
                        out_valid_d = 1'b1;
                        state_d     = IDLE;
                    end else if (idx_q == IW'(NCOEFF - 1)) begin
                        load_done_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        fcoef_d = coeff_q[idx_q + 1'b1];
                        state_d = C_REQ;
                    end
                end else if (tmo_hit) begin
                    state_d = FAULT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == FAULT) begin
            timeout_d   = 1'b1;
            load_done_d = 1'b0;
        end

        // Cleared on every entry, only advances while awaiting an edge.
        if (state_d != state_q) begin
            tcnt_d = '0;
        end else if (state_q == C_REQ || state_q == S_REQ ||
                     state_q == WAIT_LOW) begin
            tcnt_d = tcnt_q + 1'b1;
        end else begin
            tcnt_d = '0;
        end

        load_coeff_d = (state_d == C_REQ);
        data_ready_d = (state_d == S_REQ);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            tcnt_q       <= '0;
            pending_q    <= 1'b0;
            ctxn_q       <= 1'b0;
            load_done_q  <= 1'b0;
            timeout_q    <= 1'b0;
            load_coeff_q <= 1'b0;
            data_ready_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_err_q    <= 1'b0;
            out_data_q   <= '0;
            sample_q     <= '0;
            fcoef_q      <= '0;
            for (int i = 0; i < NCOEFF; i++) begin
                coeff_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            tcnt_q       <= tcnt_d;
            pending_q    <= pending_d;
            ctxn_q       <= ctxn_d;
            load_done_q  <= load_done_d;
            timeout_q    <= timeout_d;
            load_coeff_q <= load_coeff_d;
            data_ready_q <= data_ready_d;
            out_valid_q  <= out_valid_d;
            out_err_q    <= out_err_d;
            out_data_q   <= out_data_d;
            sample_q     <= sample_d;
            fcoef_q      <= fcoef_d;
            for (int i = 0; i < NCOEFF; i++) begin
                coeff_q[i] <= coeff_d[i];
            end
        end
    end

    assign bus.load_done       = load_done_q;
    assign bus.in_ready        = in_ready_w;
    assign bus.out_valid       = out_valid_q;
    assign bus.out_data        = out_data_q;
    assign bus.out_err         = out_err_q;
    assign bus.sample_data     = sample_q;
    assign bus.fir_coefficient = fcoef_q;
    assign bus.load_coeff      = load_coeff_q;
    assign bus.data_ready      = data_ready_q;
    assign bus.timeout         = timeout_q;
endmodule

// File: tb/tb_fir_host_driver.sv
// Directed bench for fir_host_driver with a behavioural filter model
// (busy 3 cycles after a strobe, idle again 5 cycles later).
module tb_fir_host_driver;
    logic clk = 1'b0;
    logic rst;

    fir_host_driver_if #(.DW(16), .AW(2)) bif ();

    fir_host_driver #(.NCOEFF(4), .DW(16), .TIMEOUT(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mism     = 0;

    bit          respond = 1'b1;
    bit          active  = 1'b0;
    int          mcnt    = 0;
    int          dr_count = 0;
    int          dr_hi    = 0;
    int          both_hi  = 0;
    logic [15:0] coeff_log [$];

    always @(negedge clk) begin
        if (rst) begin
            active      = 1'b0;
            mcnt        = 0;
            bif.modwait = 1'b0;
            bif.fir_out = 16'h0;
        end else if (!active) begin
            if (respond && (bif.load_coeff || bif.data_ready)) begin
                active = 1'b1;
                mcnt   = 0;
                if (bif.load_coeff) coeff_log.push_back(bif.fir_coefficient);
                else dr_count++;
            end
        end else begin
            mcnt++;
            if (mcnt == 3) begin
                bif.modwait = 1'b1;
                bif.fir_out = bif.sample_data + 16'h1;
            end
            if (mcnt == 8) begin
                bif.modwait = 1'b0;
                active      = 1'b0;
            end
        end
        if (bif.data_ready) dr_hi++;
        if (bif.load_coeff && bif.data_ready) both_hi++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mism++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit cond(input int which);
        case (which)
            0: return bif.in_ready;
            1: return bif.out_valid;
            2: return bif.load_done && coeff_log.size() == 4;
            default: return bif.timeout;
        endcase
    endfunction

    task automatic wait_for(input string tag, input int which,
                            input int maxc);
        bit ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (cond(which)) begin
                ok = 1'b1;
                break;
            end
        end
        chk(tag, 32'(ok), 32'h1);
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [15:0] d);
        bif.cfg_we   = 1'b1;
        bif.cfg_addr = a;
        bif.cfg_data = d;
        @(negedge clk);
        bif.cfg_we   = 1'b0;
    endtask

    task automatic pulse_start();
        bif.start_load = 1'b1;
        @(negedge clk);
        bif.start_load = 1'b0;
    endtask

    task automatic send_sample(input logic [15:0] d);
        wait_for("in_ready_wait", 0, 200);
        bif.in_valid = 1'b1;
        bif.in_data  = d;
        @(negedge clk);
        bif.in_valid = 1'b0;
    endtask

    task automatic get_result(input string tag, input logic [15:0] d,
                              input logic e);
        wait_for({tag, "_wait"}, 1, 200);
        chk({tag, "_data"}, 32'(bif.out_data), 32'(d));
        chk({tag, "_err"}, 32'(bif.out_err), 32'(e));
        bif.out_ready = 1'b1;
        @(negedge clk);
        bif.out_ready = 1'b0;
        chk({tag, "_cleared"}, 32'(bif.out_valid), 32'h0);
    endtask

    task automatic chk_log(input string tag, input logic [15:0] c3);
        logic [15:0] exp [4];
        exp[0] = 16'h1;
        exp[1] = 16'h2;
        exp[2] = 16'h3;
        exp[3] = c3;
        chk({tag, "_n"}, 32'(coeff_log.size()), 32'h4);
        for (int i = 0; i < 4 && i < coeff_log.size(); i++) begin
            chk($sformatf("%s_c%0d", tag, i), 32'(coeff_log[i]),
                32'(exp[i]));
        end
    endtask

    initial begin
        int dr0;
        rst            = 1'b1;
        bif.cfg_we     = 1'b0;
        bif.cfg_addr   = 2'd0;
        bif.cfg_data   = 16'h0;
        bif.start_load = 1'b0;
        bif.in_valid   = 1'b0;
        bif.in_data    = 16'h0;
        bif.out_ready  = 1'b0;
        bif.err        = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        chk("rst_load_done", 32'(bif.load_done), 32'h0);
        chk("rst_in_ready", 32'(bif.in_ready), 32'h0);
        chk("rst_out_valid", 32'(bif.out_valid), 32'h0);
        chk("rst_out_data", 32'(bif.out_data), 32'h0);
        chk("rst_strobes", 32'({bif.load_coeff, bif.data_ready}), 32'h0);
        chk("rst_timeout", 32'(bif.timeout), 32'h0);
        chk("rst_sample", 32'(bif.sample_data), 32'h0);
        chk("rst_coef", 32'(bif.fir_coefficient), 32'h0);

        cfg_write(2'd0, 16'h0001);
        cfg_write(2'd1, 16'h0002);
        cfg_write(2'd2, 16'h0003);
        cfg_write(2'd3, 16'h0004);
        coeff_log.delete();
        pulse_start();
        wait_for("load1_done", 2, 400);
        chk_log("load1", 16'h4);
        chk("load1_flag", 32'(bif.load_done), 32'h1);

        send_sample(16'h0010);
        get_result("s10_nohold", 16'h0011, 1'b0);

        send_sample(16'h0010);
        wait_for("s10_wait", 1, 200);
        chk("s10_data", 32'(bif.out_data), 32'h11);
        dr0 = dr_count;
        bif.in_valid = 1'b1;
        bif.in_data  = 16'h0020;
        repeat (20) @(negedge clk);
        chk("hold_in_ready", 32'(bif.in_ready), 32'h0);
        chk("hold_no_dr", 32'(dr_count), 32'(dr0));
        chk("hold_out_valid", 32'(bif.out_valid), 32'h1);
        bif.out_ready = 1'b1;
        @(negedge clk);
        bif.out_ready = 1'b0;
        chk("ack_in_ready", 32'(bif.in_ready), 32'h1);
        @(negedge clk);
        bif.in_valid = 1'b0;
        get_result("s20", 16'h0021, 1'b0);
        send_sample(16'h0030);
        get_result("s30", 16'h0031, 1'b0);

        respond = 1'b0;
        dr_hi   = 0;
        send_sample(16'h0040);
        wait_for("fault_wait", 3, 300);
        chk("fault_dr_cycles", 32'(dr_hi), 32'd64);
        chk("fault_load_done", 32'(bif.load_done), 32'h0);
        chk("fault_in_ready", 32'(bif.in_ready), 32'h0);
        chk("fault_strobes", 32'({bif.load_coeff, bif.data_ready}), 32'h0);
        repeat (10) @(negedge clk);
        chk("fault_sticky", 32'(bif.timeout), 32'h1);
        respond = 1'b1;
        coeff_log.delete();
        pulse_start();
        wait_for("load2_done", 2, 400);
        chk_log("load2", 16'h4);
        chk("load2_timeout", 32'(bif.timeout), 32'h0);

        cfg_write(2'd3, 16'h0033);
        coeff_log.delete();
        bif.err = 1'b1;
        send_sample(16'h0050);
        @(negedge clk);
        pulse_start();
        wait_for("s50_wait", 1, 200);
        chk("s50_data", 32'(bif.out_data), 32'h51);
        chk("s50_err", 32'(bif.out_err), 32'h1);
        chk("s50_before_reload", 32'(coeff_log.size()), 32'h0);
        bif.err       = 1'b0;
        bif.out_ready = 1'b1;
        @(negedge clk);
        bif.out_ready = 1'b0;
        wait_for("load3_done", 2, 400);
        chk_log("load3", 16'h33);
        send_sample(16'h0060);
        get_result("s60", 16'h0061, 1'b0);

        chk("never_both_strobes", 32'(both_hi), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mism);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1, "watchdog");
    end
endmodule
